// File: rtl/cpu_pkg.sv
// Shared opcode/phase definitions for the 8-bit accumulator CPU.
package cpu_pkg;

  localparam int unsigned NUM_PHASES = 8;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_e;

  // Opcodes that read a memory operand into the accumulator path.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_phase_counter.sv
// Instruction phase counter: wraps through NUM_PHASES, advances on ena unless held.
module cpu_phase_counter
  import cpu_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ena_i,
  input  logic       hold_i,
  output logic [2:0] phase_o
);

  logic [2:0] phase_q, phase_d;

  // Next phase: advance with wrap when enabled and not held.
  always_comb begin
    phase_d = phase_q;
    if (ena_i && !hold_i) begin
      if (phase_q == 3'(NUM_PHASES - 1)) phase_d = '0;
      else                               phase_d = phase_q + 3'd1;
    end
  end

  // Phase register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) phase_q <= '0;
    else         phase_q <= phase_d;
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/cpu_controller.sv
// Instruction sequencer: steps eight phases per instruction and decodes strobes.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       data_e,
  output logic       wr,
  output logic       halt,
  output logic [2:0] phase
);

  logic [2:0] phase_w;
  phase_e     ph;
  logic [2:0] op_q, op_d;
  logic       halted_q, halted_d;
  logic       halt_req;
  logic [2:0] op_src;
  logic       aluop;

  assign ph       = phase_e'(phase_w);
  // Phase 4 decodes the live IR; later phases use the copy captured leaving phase 4.
  assign op_src   = (ph == PH_OP_ADDR) ? opcode : op_q;
  assign aluop    = is_aluop(op_src);
  assign halt_req = !halted_q && (ph == PH_OP_ADDR) && (opcode == OP_HLT);

  // Counter freezes at phase 4 on the halting edge and stays there.
  cpu_phase_counter u_phase (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .ena_i   (ena),
    .hold_i  (halted_q | halt_req),
    .phase_o (phase_w)
  );

  // Opcode capture and halt latch next-state.
  always_comb begin
    op_d     = op_q;
    halted_d = halted_q;
    if (ena && !halted_q && (ph == PH_OP_ADDR)) begin
      op_d = opcode;
      if (opcode == OP_HLT) halted_d = 1'b1;
    end
  end

  // Opcode and halt registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      op_q     <= op_d;
      halted_q <= halted_d;
    end
  end

  // Strobe decode from phase, opcode source, zero flag and halt state.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    data_e = 1'b0;
    wr     = 1'b0;
    halt   = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      unique case (ph)
        PH_INST_ADDR:  sel = 1'b1;
        PH_INST_FETCH: begin sel = 1'b1; rd = 1'b1; end
        PH_INST_LOAD,
        PH_IDLE:       begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
        PH_OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (op_src == OP_HLT);
        end
        PH_OP_FETCH:   rd = aluop;
        PH_ALU_OP: begin
          rd     = aluop;
          inc_pc = (op_src == OP_SKZ) && zero;
          ld_pc  = (op_src == OP_JMP);
          data_e = (op_src == OP_STO);
        end
        PH_STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = (op_src == OP_JMP);
          data_e = (op_src == OP_STO);
          wr     = (op_src == OP_STO);
        end
        default: ;
      endcase
    end
  end

  assign phase = phase_w;

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: behavioural model checked every cycle, plus directed literals.
module tb_cpu_controller;

  logic       clk = 1'b0;
  logic       rst_n, ena, zero;
  logic [2:0] opcode;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt;
  logic [2:0] phase;
  logic [8:0] outs;

  int checks = 0;
  int errors = 0;

  // Model state
  int m_ph    = 0;
  int m_op    = 0;
  bit m_hlt   = 1'b0;
  bit m_valid = 1'b0;

  always #5 clk = ~clk;

  cpu_controller dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
    .ld_ac(ld_ac), .data_e(data_e), .wr(wr), .halt(halt), .phase(phase)
  );

  // {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,data_e,wr,halt}
  assign outs = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt};

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected strobes from the instruction-phase rules.
  function automatic logic [8:0] model_outs(input int ph, input int opq, input bit hlt,
                                             input int live_op, input bit z);
    int  op;
    bit  alu, s, r, li, ip, lp, la, de, w, h;
    if (hlt) return 9'b000000001;
    op  = (ph == 4) ? live_op : opq;
    alu = (op >= 2) && (op <= 5);
    s   = (ph < 4);
    r   = ((ph >= 1) && (ph <= 3)) || ((ph >= 5) && alu);
    li  = (ph == 2) || (ph == 3);
    ip  = (ph == 4) || ((ph == 6) && (op == 1) && z);
    lp  = (ph >= 6) && (op == 7);
    la  = (ph == 7) && alu;
    de  = (ph >= 6) && (op == 6);
    w   = (ph == 7) && (op == 6);
    h   = (ph == 4) && (op == 0);
    return {s, r, li, ip, lp, la, de, w, h};
  endfunction

  // Model state update on every active edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_ph = 0; m_op = 0; m_hlt = 1'b0; m_valid = 1'b1;
    end else if (m_valid && ena && !m_hlt) begin
      if (m_ph == 4) begin
        m_op = int'(opcode);
        if (opcode == 3'd0) m_hlt = 1'b1;
        else                m_ph = 5;
      end else begin
        m_ph = (m_ph + 1) % 8;
      end
    end
  end

  // Continuous compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_phase", {6'd0, phase}, 9'(m_ph));
      chk("model_outs", outs, model_outs(m_ph, m_op, m_hlt, int'(opcode), zero));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Step through one instruction from phase 0 (inputs held).
  task automatic run_instr();
    for (int p = 0; p < 8; p++) cyc();
  endtask

  logic [8:0] exp_add [8];

  initial begin
    exp_add[0] = 9'b100000000;
    exp_add[1] = 9'b110000000;
    exp_add[2] = 9'b111000000;
    exp_add[3] = 9'b111000000;
    exp_add[4] = 9'b000100000;
    exp_add[5] = 9'b010000000;
    exp_add[6] = 9'b010000000;
    exp_add[7] = 9'b010001000;

    rst_n = 1'b0; ena = 1'b1; opcode = 3'd2; zero = 1'b0;
    cyc();
    rst_n = 1'b1;

    // ADD walk through all phases
    for (int p = 0; p < 8; p++) begin
      #3;
      chk("add_phase", {6'd0, phase}, 9'(p));
      chk("add_outs", outs, exp_add[p]);
      cyc();
    end
    #3 chk("add_wrap", {6'd0, phase}, 9'd0);

    // STO
    opcode = 3'd6;
    for (int p = 0; p < 8; p++) begin
      #3;
      if (p == 5) chk("sto_p5", outs, 9'b000000000);
      if (p == 6) chk("sto_p6", outs, 9'b000000100);
      if (p == 7) chk("sto_p7", outs, 9'b000000110);
      cyc();
    end

    // SKZ with zero=1: two increments
    opcode = 3'd1; zero = 1'b1;
    for (int p = 0; p < 8; p++) begin
      #3;
      if (p == 4) chk("skz1_p4", outs, 9'b000100000);
      if (p == 6) chk("skz1_p6", outs, 9'b000100000);
      cyc();
    end

    // SKZ with zero=0, zero pulsed only in phase 5
    zero = 1'b0;
    for (int p = 0; p < 8; p++) begin
      if (p == 5) zero = 1'b1;
      if (p == 6) zero = 1'b0;
      #3;
      if (p == 6) chk("skz0_p6", outs, 9'b000000000);
      cyc();
    end

    // ena low for 3 cycles in phase 2
    opcode = 3'd2;
    cyc(); cyc();
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("stall_phase", {6'd0, phase}, 9'd2);
      chk("stall_outs", outs, 9'b111000000);
      cyc();
    end
    ena = 1'b1;
    cyc();
    #3 chk("stall_resume", {6'd0, phase}, 9'd3);
    for (int p = 3; p < 8; p++) cyc();

    // JMP, reset in phase 6
    opcode = 3'd7;
    for (int p = 0; p < 6; p++) cyc();
    #3 chk("jmp_p6", outs, 9'b000010000);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #3 chk("jmp_rst_outs", outs, 9'b100000000);
    chk("jmp_rst_phase", {6'd0, phase}, 9'd0);

    // JMP captured in phase 4, opcode changed to XOR afterwards
    for (int p = 0; p < 8; p++) begin
      if (p == 5) opcode = 3'd4;
      #3;
      if (p == 6) chk("cap_p6", outs, 9'b000010000);
      if (p == 7) chk("cap_p7", outs, 9'b000010000);
      cyc();
    end

    // HLT
    opcode = 3'd0;
    for (int p = 0; p < 4; p++) cyc();
    #3 chk("hlt_p4", outs, 9'b000100001);
    cyc();
    for (int i = 0; i < 10; i++) begin
      #3;
      chk("halted_phase", {6'd0, phase}, 9'd4);
      chk("halted_outs", outs, 9'b000000001);
      opcode = 3'(i);
      cyc();
    end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #3 chk("hlt_exit_outs", outs, 9'b100000000);
    chk("hlt_exit_phase", {6'd0, phase}, 9'd0);
    cyc();

    // Randomized traffic, checked by the model on every cycle
    for (int i = 0; i < 600; i++) begin
      ena    = ($urandom % 8) != 0;
      opcode = 3'($urandom % 8);
      zero   = 1'($urandom % 2);
      if (m_hlt) rst_n = ($urandom % 6) != 0;
      else       rst_n = ($urandom % 64) != 0;
      cyc();
    end
    rst_n = 1'b1;

    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
Instruction sequencer for the 8-bit accumulator CPU. It owns a 3-bit phase counter and steps every instruction through eight fixed phases. From the phase, the instruction opcode and the ALU zero flag, it decodes the memory, IR, PC, accumulator and bus strobes. It sits between the instruction register and ALU on one side and the memory/PC/accumulator load enables on the other.

Parameters:
- NUM_PHASES, 8, phases per instruction. Fixed; the counter is 3 bits wide.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- ena  input  1  phase advance enable; when low, all state holds.
- opcode  input  3  current IR opcode. 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP.
- zero  input  1  ALU accumulator-is-zero flag.
- sel  output  1  address mux select: 1 = PC, 0 = IR operand.
- rd  output  1  memory read enable.
- ld_ir  output  1  instruction register load.
- inc_pc  output  1  PC increment.
- ld_pc  output  1  PC load (jump).
- ld_ac  output  1  accumulator load.
- data_e  output  1  accumulator drives data bus.
- wr  output  1  memory write strobe.
- halt  output  1  halt indication.
- phase  output  3  current phase, for debug and bench.

Behaviour:
- State:
  - phase_q[2:0]
  - op_q[2:0], the opcode captured at the end of phase 4
  - halted_q
- Reset (rst_n low at rising edge):
  - phase_q=0, op_q=0, halted_q=0.
  - Resulting outputs: sel=1, all other strobes 0, halt=0, phase=0.
  - Reset overrides ena and halted_q.
  - Outputs are undefined before the first reset edge.
- Phase advance: if ena=1 and halted_q=0, phase_q <= phase_q+1, wrapping 7->0. Otherwise phase_q holds.
- Opcode capture: op_q <= opcode at the edge leaving phase 4 (ena=1, phase_q=4, halted_q=0).
- Opcode source for decode: phase 4 uses the live opcode; phases 5-7 use op_q. Phases 0-3 ignore opcode, because the IR is being refilled.
- ALUOP = op is ADD, AND, XOR or LDA.
- Outputs are combinational from phase_q, the opcode source, zero and halted_q. There are no output registers; latency from phase_q is 0.
- Phase decode (strobes not listed are 0):
  - 0 INST_ADDR: sel
  - 1 INST_FETCH: sel, rd
  - 2 INST_LOAD: sel, rd, ld_ir
  - 3 IDLE: sel, rd, ld_ir
  - 4 OP_ADDR: inc_pc; halt if opcode==HLT
  - 5 OP_FETCH: rd if ALUOP
  - 6 ALU_OP:
    - rd if ALUOP
    - inc_pc if SKZ and zero
    - ld_pc if JMP
    - data_e if STO
  - 7 STORE:
    - rd and ld_ac if ALUOP
    - ld_pc if JMP
    - data_e and wr if STO
- Halt:
  - In phase 4 with opcode==HLT, halt=1 and inc_pc=1 for that cycle.
  - If ena=1 at that edge, halted_q <= 1 and phase_q stays at 4.
  - While halted_q=1: halt=1, phase=4, all other strobes 0, counter frozen.
  - Only reset exits halt.
- ena low mid-instruction: the outputs of the current phase stay asserted for every held cycle. The consumer qualifies the strobes with ena.
- zero is sampled live in phase 6 only; it is ignored in every other phase.
- Reset in any phase, including while halted, returns to phase 0 on the next edge with no partial strobes afterwards.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants OP_HLT..OP_JMP (3 bits)
  - phase constants PH_INST_ADDR..PH_STORE
  - ALUOP membership helper function
- The ALU uses the same opcode constants.
- One sub-module: cpu_phase_counter (3-bit wrap counter with ena, hold, sync active-low reset). Decode and halt latch stay in cpu_controller.

Test Plan:
- Reset, ena=1, opcode=ADD, 8 cycles -> phase 0..7 once. Per phase:
  - 0: sel
  - 1: sel, rd
  - 2-3: sel, rd, ld_ir
  - 4: inc_pc
  - 5-6: rd
  - 7: rd, ld_ac
  - Next cycle phase=0.
- opcode=STO -> data_e=1 in phases 6-7; wr=1 only in phase 7; ld_ac=0 and rd=0 in phases 5-7.
- opcode=SKZ:
  - zero=1 -> inc_pc=1 in phase 4 and phase 6 (two increments).
  - zero=0 -> inc_pc only in phase 4.
  - zero toggled in phase 5 has no effect.
- opcode=HLT -> phase 4 shows halt=1 and inc_pc=1. For the next 10 cycles: phase=4, halt=1, all other strobes 0. Then rst_n=0 for one edge -> phase=0, sel=1, halt=0.
- ena=0 held 3 cycles in phase 2 -> phase stays 2 with sel, rd, ld_ir high; ena=1 -> phase 3 next edge.
- opcode=JMP, rst_n=0 at phase 6 -> next cycle phase=0, ld_pc=0, data_e=0. Then opcode changed to XOR during phases 5-7 of the next instruction -> decode follows the opcode captured in phase 4.
